// File: rtl/pll_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq
// Purpose  : rPLL reset/lock sequencer with lock qualification, retry on
//            timeout or lock loss, and handshaked phase/duty updates.
// Revision : 1.0
// ============================================================================
module pll_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 255,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ready,
    output logic       clk_ok,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int RC_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int ST_W = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST  = ST_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]      RETRY_MX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RUN       = 3'd2,
        ST_APPLY     = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            lock_meta_q, lock_s_q;
    logic [RC_W-1:0] cyc_q, cyc_d;
    logic [ST_W-1:0] stab_q, stab_d;
    logic [TO_W-1:0] tout_q, tout_d;
    logic [1:0]      retry_q, retry_d;
    logic [3:0]      psda_q, psda_d;
    logic [3:0]      duty_q, duty_d;
    logic            pll_reset_q, clk_ok_q, fail_q;

    logic [1:0]      retry_inc;
    state_t          retry_tgt;

    // pll_lock is asynchronous to clk; only lock_s_q feeds decisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    assign retry_tgt = (retry_inc == RETRY_MX) ? ST_FAILED : ST_RST_PLL;
    assign cfg_ready = (state_q == ST_RUN) && lock_s_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = '0;
        stab_d  = '0;
        tout_d  = '0;
        retry_d = retry_q;
        psda_d  = psda_q;
        duty_d  = duty_q;

        case (state_q)
            ST_RST_PLL: begin
                if (cyc_q == RC_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cyc_d = cyc_q + RC_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                tout_d = tout_q + TO_W'(1);
                stab_d = lock_s_q ? (stab_q + ST_W'(1)) : '0;
                // A qualified lock takes priority over a coincident timeout.
                if (lock_s_q && (stab_q == ST_LAST)) begin
                    state_d = ST_RUN;
                    retry_d = 2'd0;
                end else if (tout_q == TO_LAST) begin
                    state_d = retry_tgt;
                    retry_d = retry_inc;
                end
            end

            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = retry_tgt;
                    retry_d = retry_inc;
                end else if (cfg_valid && cfg_ready) begin
                    state_d = ST_APPLY;
                    psda_d  = cfg_psda;
                    duty_d  = cfg_dutyda;
                end
            end

            ST_APPLY: begin
                if (cyc_q == RC_LAST) begin
                    if (lock_s_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = retry_tgt;
                        retry_d = retry_inc;
                    end
                end else begin
                    cyc_d = cyc_q + RC_W'(1);
                end
            end

            ST_FAILED: begin
                state_d = ST_FAILED;
            end

            default: begin
                state_d = ST_RST_PLL;
            end
        endcase
    end

    // Flag outputs are decoded from the next state so they move on the
    // same edge as the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RST_PLL;
            cyc_q       <= '0;
            stab_q      <= '0;
            tout_q      <= '0;
            retry_q     <= 2'd0;
            psda_q      <= 4'b0000;
            duty_q      <= 4'b1000;
            pll_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stab_q      <= stab_d;
            tout_q      <= tout_d;
            retry_q     <= retry_d;
            psda_q      <= psda_d;
            duty_q      <= duty_d;
            pll_reset_q <= (state_d == ST_RST_PLL) || (state_d == ST_FAILED);
            clk_ok_q    <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAILED);
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_psda   = psda_q;
    assign pll_dutyda = duty_q;
    assign clk_ok     = clk_ok_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_seq
// Purpose  : Directed, table-driven self-checking bench for pll_seq.
// Revision : 1.0
// ============================================================================
module tb_pll_seq;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pll_lock   = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [3:0] cfg_psda   = 4'h0;
    logic [3:0] cfg_dutyda = 4'h0;
    logic       pll_reset;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       cfg_ready;
    logic       clk_ok;
    logic       fail;
    logic [1:0] retry_cnt;

    pll_seq #(
        .RST_CYCLES   (16),
        .LOCK_STABLE  (255),
        .LOCK_TIMEOUT (1000),
        .MAX_RETRY    (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .cfg_valid  (cfg_valid),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ready  (cfg_ready),
        .clk_ok     (clk_ok),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    // Each record: at cycle cyc compare outputs, then drive the inputs listed.
    typedef struct {
        int         cyc;
        logic       lock;
        logic       cv;
        logic [3:0] cp;
        logic [3:0] cd;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    // Packing: {pll_reset, clk_ok, cfg_ready, fail, retry_cnt, pll_psda, pll_dutyda}
    function automatic logic [13:0] obs();
        return {pll_reset, clk_ok, cfg_ready, fail, retry_cnt, pll_psda, pll_dutyda};
    endfunction

    function automatic logic [13:0] e(input logic r, input logic ok, input logic rdy,
                                      input logic f, input logic [1:0] rc,
                                      input logic [3:0] p, input logic [3:0] d);
        return {r, ok, rdy, f, rc, p, d};
    endfunction

    task automatic add(input int c, input logic l, input logic v,
                       input logic [3:0] p, input logic [3:0] d, input logic [13:0] x);
        vec_t t;
        t.cyc = c; t.lock = l; t.cv = v; t.cp = p; t.cd = d; t.exp = x;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rst=%b ok=%b rdy=%b fail=%b retry=%0d psda=%h duty=%h, expected rst=%b ok=%b rdy=%b fail=%b retry=%0d psda=%h duty=%h",
                     name, act[13], act[12], act[11], act[10], act[9:8], act[7:4], act[3:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) step();
            check($sformatf("%s@%0d", tag, tbl[i].cyc), obs(), tbl[i].exp);
            pll_lock   = tbl[i].lock;
            cfg_valid  = tbl[i].cv;
            cfg_psda   = tbl[i].cp;
            cfg_dutyda = tbl[i].cd;
        end
        tbl.delete();
    endtask

    // Release lands on a falling edge; cycle 0 is the interval before edge 1.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        pll_lock  = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        // Power-up: lock appears 100 cycles after release.
        do_reset();
        add(0,   1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(15,  1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(16,  1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(100, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(356, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(357, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h0, 4'h8));
        run_tbl("pwr");

        // One-cycle lock glitch restarts qualification without a retry.
        do_reset();
        add(0,   1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(20,  1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(220, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(221, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(300, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(477, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(478, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h0, 4'h8));
        run_tbl("glitch");

        // Config apply, then lock loss coinciding with a request, then relock.
        do_reset();
        add(0,   1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(100, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(357, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h0, 4'h8));
        add(360, 1'b1, 1'b1, 4'h5, 4'h9, e(0, 1, 1, 0, 2'd0, 4'h0, 4'h8));
        add(361, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h5, 4'h9));
        add(376, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h5, 4'h9));
        add(377, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h5, 4'h9));
        add(400, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h5, 4'h9));
        add(401, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h5, 4'h9));
        add(402, 1'b0, 1'b1, 4'h3, 4'h4, e(0, 1, 0, 0, 2'd0, 4'h5, 4'h9));
        add(403, 1'b1, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd1, 4'h5, 4'h9));
        add(418, 1'b1, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd1, 4'h5, 4'h9));
        add(419, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd1, 4'h5, 4'h9));
        add(673, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd1, 4'h5, 4'h9));
        add(674, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 1, 1, 0, 2'd0, 4'h5, 4'h9));
        add(680, 1'b1, 1'b1, 4'hA, 4'h3, e(0, 1, 1, 0, 2'd0, 4'h5, 4'h9));
        add(681, 1'b1, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'hA, 4'h3));
        run_tbl("cfg");

        // Asynchronous reset mid-APPLY must act before any clock edge.
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_apply", obs(), e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));

        // Lock stuck low: three reset pulses, then FAILED ignores lock.
        do_reset();
        add(16,   1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(1015, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd0, 4'h0, 4'h8));
        add(1016, 1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd1, 4'h0, 4'h8));
        add(1031, 1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd1, 4'h0, 4'h8));
        add(1032, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd1, 4'h0, 4'h8));
        add(2031, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd1, 4'h0, 4'h8));
        add(2032, 1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd2, 4'h0, 4'h8));
        add(2047, 1'b0, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 0, 2'd2, 4'h0, 4'h8));
        add(2048, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd2, 4'h0, 4'h8));
        add(3047, 1'b0, 1'b0, 4'h0, 4'h0, e(0, 0, 0, 0, 2'd2, 4'h0, 4'h8));
        add(3048, 1'b1, 1'b0, 4'h0, 4'h0, e(1, 0, 0, 1, 2'd3, 4'h0, 4'h8));
        add(3400, 1'b1, 1'b1, 4'h7, 4'h7, e(1, 0, 0, 1, 2'd3, 4'h0, 4'h8));
        run_tbl("tmo");

        do_reset();
        check("reset_clears_fail", obs(), e(1, 0, 0, 0, 2'd0, 4'h0, 4'h8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
